// File: rtl/pixel_pkg.sv
// Shared pixel definitions for the drawing engines (fillscreen, circle, line) and the pixel FIFO.
// Holds the screen geometry, the packed {x,y,colour} pixel record and an on-screen test.
// No ports; import with "import pixel_pkg::*;".
package pixel_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  // 18-bit pixel record: x in [17:10], y in [9:3], colour in [2:0].
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } pixel_t;

  // True when the pixel lies inside a w x h screen anchored at (0,0).
  function automatic logic on_screen(input pixel_t p, input int w, input int h);
    return (int'(p.x) < w) && (int'(p.y) < h);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Pixel storage: DEPTH x pixel_t array, synchronous write, registered read with write-first bypass.
// Latency: rd_dat_o reflects the addressed entry one cycle after rd_en_i; holds when rd_en_i is low.
// Backpressure: none; the owner decides when to read and write.
// Ports: clk, rst_n (sync, active-low, clears only the read register),
//        wr_en_i/wr_addr_i/wr_dat_i write port, rd_en_i/rd_addr_i read request, rd_dat_o registered data.
module fifo_ram
  import pixel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  pixel_t        wr_dat_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output pixel_t        rd_dat_o
);

  pixel_t mem_q [DEPTH];
  pixel_t rd_q;
  pixel_t rd_d;

  // The array itself is never reset: validity is tracked by the owner's count.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Write-first: a read of the location being written this cycle returns the
  // new data. This is what lets a pixel pushed into an empty (or draining to
  // empty) FIFO appear on the output one cycle later without a bubble.
  always_comb begin
    rd_d = rd_q;
    if (rd_en_i) begin
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_d = wr_dat_i;
      end else begin
        rd_d = mem_q[rd_addr_i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_dat_o = rd_q;

endmodule

// File: rtl/pixel_fifo.sv
// Elastic pixel buffer between a drawing engine and the VGA adapter; off-screen requests are consumed, counted, discarded.
// Latency: a pixel accepted into an empty FIFO is presented on vga_* the cycle after acceptance; one pixel/cycle sustained.
// Backpressure: in_ready = !full from registered count only; a pop while full does not admit a push that cycle.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_x/in_y/in_colour producer side;
//        out_ready, vga_x/vga_y/vga_colour/vga_plot consumer side; count/empty/full occupancy; dropped off-screen counter.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = pixel_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_pkg::SCREEN_H
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_x,
  input  logic [6:0]               in_y,
  input  logic [2:0]               in_colour,
  input  logic                     out_ready,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic [15:0]              dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [15:0]   DROP_MAX = 16'hFFFF;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [15:0]   dropped_q, dropped_d;

  pixel_t        in_pix;
  pixel_t        head_pix;
  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  assign in_pix.x      = in_x;
  assign in_pix.y      = in_y;
  assign in_pix.colour = in_colour;

  // Occupancy flags come straight from the count register, so in_ready has
  // no combinational dependence on out_ready.
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign in_ready = !full;
  assign vga_plot = !empty;

  assign accept   = in_valid && in_ready;
  assign in_range = on_screen(in_pix, SCREEN_W, SCREEN_H);
  assign push     = accept && in_range;
  assign pop      = vga_plot && out_ready;

  // The RAM read register is the output stage and always holds the entry at
  // rd_ptr. It is reloaded when the head changes:
  //  - empty and pushing: the new pixel becomes head (via write-first bypass);
  //  - popping with another entry behind it, either already stored
  //    (count > 1) or arriving this very cycle (count == 1 with a push).
  // A pop that leaves the FIFO empty leaves the fields untouched.
  assign rd_en   = (empty && push) || (pop && ((count_q != ONE_CNT) || push));
  assign rd_addr = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase

    if (accept && !in_range && (dropped_q != DROP_MAX)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_dat_i  (in_pix),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_dat_o  (head_pix)
  );

  assign vga_x      = head_pix.x;
  assign vga_y      = head_pix.y;
  assign vga_colour = head_pix.colour;
  assign count      = count_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_pixel_fifo.sv
module tb_pixel_fifo;
  import pixel_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        out_ready;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic [15:0] dropped;

  always #5 clk = ~clk;

  pixel_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .out_ready  (out_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .dropped    (dropped)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an ordered queue of stored pixels, the last pixel that
  // was on display, and the drop count.
  pixel_t mq[$];
  pixel_t m_last;
  int     m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int x, input int y, input int c);
    in_valid  = v;
    in_x      = 8'(x);
    in_y      = 7'(y);
    in_colour = 3'(c);
  endtask

  task automatic check_outputs();
    chk("count",    32'(count),    32'(mq.size()));
    chk("empty",    32'(empty),    32'(mq.size() == 0));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("vga_plot", 32'(vga_plot), 32'(mq.size() > 0));
    chk("vga_x",    32'(vga_x),    32'(m_last.x));
    chk("vga_y",    32'(vga_y),    32'(m_last.y));
    chk("vga_col",  32'(vga_colour), 32'(m_last.colour));
    chk("dropped",  32'(dropped),  32'(m_drop));
  endtask

  // One clock: model the handshake from the inputs held across the edge,
  // then compare every output #1 after the edge.
  task automatic cycle();
    bit     rst_now, acc, pop, onscr;
    pixel_t p;
    rst_now = !rst_n;
    acc     = in_valid && (mq.size() < DEPTH);
    pop     = out_ready && (mq.size() > 0);
    onscr   = (int'(in_x) < 160) && (int'(in_y) < 120);
    p.x = in_x; p.y = in_y; p.colour = in_colour;
    @(posedge clk);
    #1;
    if (rst_now) begin
      mq.delete();
      m_last = '0;
      m_drop = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (onscr) mq.push_back(p);
        else if (m_drop < 65535) m_drop++;
      end
    end
    if (mq.size() > 0) m_last = mq[0];
    check_outputs();
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    m_last = '0;
    m_drop = 0;

    // Reset state
    cycle();
    cycle();
    chk("rst_plot",  32'(vga_plot), 0);
    chk("rst_empty", 32'(empty), 1);
    rst_n = 1'b1;
    cycle();

    // 1: single pixel into empty FIFO, visible next cycle
    drive(1, 10, 20, 5);
    out_ready = 1'b0;
    cycle();
    chk("t1_plot",  32'(vga_plot), 1);
    chk("t1_x",     32'(vga_x), 10);
    chk("t1_y",     32'(vga_y), 20);
    chk("t1_col",   32'(vga_colour), 5);
    chk("t1_count", 32'(count), 1);
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    cycle();

    // 2: fill with out_ready low, hold the 17th, then drain back-to-back
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 3 * i, 100 - i, i);
      cycle();
    end
    chk("t2_full",  32'(full), 1);
    chk("t2_ready", 32'(in_ready), 0);
    drive(1, 77, 77, 7);
    cycle();
    chk("t2_held",  32'(count), 16);
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain_plot", 32'(vga_plot), 1);
      chk("t2_drain_x",    32'(vga_x), 32'(3 * i));
      cycle();
    end
    chk("t2_empty", 32'(empty), 1);

    // 3: off-screen requests are consumed and counted
    drive(1, 160, 0, 1);
    chk("t3_ready_a", 32'(in_ready), 1);
    cycle();
    drive(1, 0, 120, 2);
    chk("t3_ready_b", 32'(in_ready), 1);
    cycle();
    drive(0, 0, 0, 0);
    chk("t3_dropped", 32'(dropped), 2);
    chk("t3_plot",    32'(vga_plot), 0);
    chk("t3_count",   32'(count), 0);

    // 4: full-screen column-major stream at one pixel per cycle
    for (int x = 0; x < 160; x++) begin
      for (int y = 0; y < 120; y++) begin
        drive(1, x, y, x % 8);
        cycle();
      end
    end
    drive(0, 0, 0, 0);
    cycle();
    chk("t4_count", 32'(count), 0);
    chk("t4_empty", 32'(empty), 1);
    chk("t4_last_x", 32'(vga_x), 159);
    chk("t4_last_y", 32'(vga_y), 119);
    chk("t4_last_c", 32'(vga_colour), 7);

    // 5: reset while holding entries discards them
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 50 + i, 60 + i, i);
      cycle();
    end
    drive(0, 0, 0, 0);
    chk("t5_pre", 32'(count), 5);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t5_count",   32'(count), 0);
    chk("t5_plot",    32'(vga_plot), 0);
    chk("t5_dropped", 32'(dropped), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_no_stale", 32'(vga_plot), 0);
    end

    // 6: push and pop together at count==1
    drive(1, 1, 1, 1);
    cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1, 20 + i, 30 + i, i);
      cycle();
      chk("t6_count", 32'(count), 1);
      chk("t6_plot",  32'(vga_plot), 1);
      chk("t6_x",     32'(vga_x), 32'(20 + i));
    end
    drive(0, 0, 0, 0);
    cycle();

    // Random traffic with mixed on/off-screen pixels and backpressure
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 175),
            $urandom_range(0, 127), $urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    chk("final_empty", 32'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
